// File: rtl/vec_operand_loader.sv
// vec_operand_loader: packs a serial (x,k) element stream into C-lane operand
// vectors, drives the vector MAC PE, waits for its result pulse and hands the
// truncated dot product to the consumer over a valid/ready handshake.
module vec_operand_loader #(
    parameter int C       = 8,
    parameter int W_X     = 8,
    parameter int W_K     = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_X-1:0]     in_x,
    input  logic [W_K-1:0]     in_k,
    input  logic               in_last,
    output logic               mul_enable,
    output logic [C*W_K-1:0]   mul_k,
    output logic [C*W_X-1:0]   mul_x,
    input  logic               mul_v_valid,
    input  logic [W_X-1:0]     mul_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W_X-1:0]     res_data,
    output logic               err_timeout
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_FILL,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic [W_X-1:0]   x_q [C];
    logic [W_X-1:0]   x_d [C];
    logic [W_K-1:0]   k_q [C];
    logic [W_K-1:0]   k_d [C];
    logic [W_X-1:0]   res_q, res_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             last_beat;
    logic             wait_expired;

    assign accept       = (state_q == S_FILL) && in_valid && in_ready_q;
    assign last_beat    = accept && ((cnt_q == CW'(C - 1)) || in_last);
    assign wait_expired = (wcnt_q == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fill until full/last, wait for PE or timeout, drain to consumer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL:  if (last_beat) state_d = S_WAIT;
            S_WAIT:  if (mul_v_valid || wait_expired) state_d = S_DRAIN;
            S_DRAIN: if (res_ready) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        mul_enable  = (state_q == S_WAIT);
        res_valid   = (state_q == S_DRAIN);
        in_ready    = in_ready_q;
        res_data    = res_q;
        err_timeout = err_q;
    end

    // Datapath next values: lane writes, wait counter, result capture, sticky error.
    always_comb begin
        x_d    = x_q;
        k_d    = k_q;
        cnt_d  = cnt_q;
        wcnt_d = '0;
        res_d  = res_q;
        err_d  = err_q;
        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    x_d[cnt_q] = in_x;
                    k_d[cnt_q] = in_k;
                    cnt_d      = last_beat ? '0 : cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + TW'(1);
                if (mul_v_valid) begin
                    res_d = mul_y;
                end else if (wait_expired) begin
                    res_d = '0;
                    err_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (res_ready) begin
                    x_d   = '{default: '0};
                    k_d   = '{default: '0};
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
        // in_ready follows the next state so it is registered yet aligned with FILL.
        in_ready_d = (state_d == S_FILL);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '{default: '0};
            k_q        <= '{default: '0};
            cnt_q      <= '0;
            wcnt_q     <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            res_q      <= res_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Pack lanes onto the PE buses, lane 0 in the least significant slot.
    always_comb begin
        mul_x = '0;
        mul_k = '0;
        for (int unsigned i = 0; i < C; i++) begin
            mul_x[i*W_X +: W_X] = x_q[i];
            mul_k[i*W_K +: W_K] = k_q[i];
        end
    end

endmodule

// File: tb/tb_vec_operand_loader.sv
// Testbench for vec_operand_loader with a behavioural PE and reference dot product.
module tb_vec_operand_loader;

    localparam int C       = 8;
    localparam int W_X     = 8;
    localparam int W_K     = 8;
    localparam int TIMEOUT = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [W_X-1:0]     in_x;
    logic [W_K-1:0]     in_k;
    logic               in_last;
    logic               mul_enable;
    logic [C*W_K-1:0]   mul_k;
    logic [C*W_X-1:0]   mul_x;
    logic               mul_v_valid;
    logic [W_X-1:0]     mul_y;
    logic               res_valid;
    logic               res_ready;
    logic [W_X-1:0]     res_data;
    logic               err_timeout;

    vec_operand_loader #(
        .C(C), .W_X(W_X), .W_K(W_K), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_k(in_k), .in_last(in_last),
        .mul_enable(mul_enable), .mul_k(mul_k), .mul_x(mul_x),
        .mul_v_valid(mul_v_valid), .mul_y(mul_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit pe_on  = 1'b1;
    int pe_lat = 3;

    int vx[$];
    int vk[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural PE: after pe_lat enabled cycles, pulse v_valid with the dot product.
    function automatic logic [W_X-1:0] pe_dot();
        int s = 0;
        logic [W_X-1:0] r;
        for (int i = 0; i < C; i++)
            s += int'($signed(mul_x[i*W_X +: W_X])) * int'($signed(mul_k[i*W_K +: W_K]));
        r = s[W_X-1:0];
        return r;
    endfunction

    initial begin
        int cnt = 0;
        mul_v_valid = 1'b0;
        mul_y       = '0;
        forever begin
            @(negedge clk);
            if (mul_enable && rst_n) begin
                cnt++;
                if (pe_on && cnt == pe_lat) begin
                    mul_v_valid = 1'b1;
                    mul_y       = pe_dot();
                end else begin
                    mul_v_valid = 1'b0;
                end
            end else begin
                cnt         = 0;
                mul_v_valid = 1'b0;
            end
        end
    end

    // Reference: truncated dot product of the queued elements.
    function automatic logic [W_X-1:0] ref_dot();
        int s = 0;
        logic [W_X-1:0] r;
        foreach (vx[i]) s += vx[i] * vk[i];
        r = s[W_X-1:0];
        return r;
    endfunction

    function automatic logic [63:0] ref_lanes(input bit is_k);
        logic [63:0] p = '0;
        int t;
        for (int i = 0; i < C; i++) begin
            t = (i < vx.size()) ? (is_k ? vk[i] : vx[i]) : 0;
            p[i*W_X +: W_X] = t[W_X-1:0];
        end
        return p;
    endfunction

    task automatic rand_vec(input int n);
        vx.delete();
        vk.delete();
        for (int i = 0; i < n; i++) begin
            vx.push_back(int'($urandom_range(0, 255)) - 128);
            vk.push_back(int'($urandom_range(0, 255)) - 128);
        end
    endtask

    // Send the first n queued pairs; in_last on the final one when use_last.
    task automatic send_beats(input int n, input bit use_last, input int gap_max);
        int tries;
        int t;
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            t        = vx[b];
            in_x     = t[W_X-1:0];
            t        = vk[b];
            in_k     = t[W_K-1:0];
            in_last  = use_last && (b == n - 1);
            in_valid = 1'b1;
            tries    = 0;
            while (!in_ready && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 50) chk("in_ready_timeout", 64'd0, 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Check the operand presentation right after the vector closes.
    task automatic check_wait(input string tag);
        chk({tag, "_mul_enable"}, 64'(mul_enable), 64'd1);
        chk({tag, "_in_ready"},   64'(in_ready),   64'd0);
        chk({tag, "_mul_x"},      mul_x, ref_lanes(1'b0));
        chk({tag, "_mul_k"},      mul_k, ref_lanes(1'b1));
    endtask

    // Wait for a result, hold res_ready low for `hold` cycles, then accept it.
    task automatic take_result(input string tag, input logic [W_X-1:0] exp,
                               input logic exp_err, input int hold);
        int tries = 0;
        while (!res_valid && tries < 60) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 60) chk({tag, "_res_valid_timeout"}, 64'd0, 64'd1);
        chk({tag, "_res_data"}, 64'(res_data), 64'(exp));
        chk({tag, "_err"},      64'(err_timeout), 64'(exp_err));
        chk({tag, "_en_low"},   64'(mul_enable), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(res_valid),  64'd1);
            chk({tag, "_hold_data"},  64'(res_data),   64'(exp));
            chk({tag, "_hold_rdy"},   64'(in_ready),   64'd0);
            chk({tag, "_hold_en"},    64'(mul_enable), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_post_rdy"},   64'(in_ready),  64'd1);
        chk({tag, "_post_lanes"}, mul_x,          64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready),    64'd0);
        chk({tag, "_en"},       64'(mul_enable),  64'd0);
        chk({tag, "_valid"},    64'(res_valid),   64'd0);
        chk({tag, "_data"},     64'(res_data),    64'd0);
        chk({tag, "_err"},      64'(err_timeout), 64'd0);
        chk({tag, "_x"},        mul_x,            64'd0);
        chk({tag, "_k"},        mul_k,            64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wait_cycles;
        logic [W_X-1:0] e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_k      = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdy_after", 64'(in_ready), 64'd1);

        // 1: full vector x=1..8, k=1, closed by lane count.
        vx.delete(); vk.delete();
        for (int i = 1; i <= C; i++) begin vx.push_back(i); vk.push_back(1); end
        pe_lat = 4;
        send_beats(C, 1'b0, 0);
        check_wait("t1");
        take_result("t1", 8'd36, 1'b0, 0);

        // 2: short vector closed by in_last on beat 2.
        vx = '{-3, 2};
        vk = '{4, 5};
        pe_lat = 2;
        send_beats(2, 1'b1, 0);
        check_wait("t2");
        take_result("t2", 8'hFE, 1'b0, 0);

        // 3: consumer stalls 10 cycles while a new pair is offered.
        rand_vec(C);
        pe_lat = 3;
        send_beats(C, 1'b0, 1);
        check_wait("t3");
        e = ref_dot();
        in_valid = 1'b1;
        in_x     = 8'h55;
        in_k     = 8'h11;
        take_result("t3", e, 1'b0, 10);
        in_valid = 1'b0;
        chk("t3_no_early_accept", mul_x, 64'd0);

        // 4: PE never answers -> timeout after TIMEOUT wait cycles.
        pe_on = 1'b0;
        rand_vec(5);
        send_beats(5, 1'b1, 0);
        check_wait("t4");
        wait_cycles = 0;
        while (mul_enable && wait_cycles < 100) begin
            wait_cycles++;
            @(negedge clk);
        end
        chk("t4_wait_cycles", 64'(wait_cycles), 64'(TIMEOUT));
        chk("t4_res_valid",   64'(res_valid),   64'd1);
        take_result("t4", 8'd0, 1'b1, 2);
        pe_on = 1'b1;
        for (int v = 0; v < 2; v++) begin
            rand_vec(C);
            pe_lat = 2 + v;
            send_beats(C, 1'b0, 1);
            take_result("t4_sticky", ref_dot(), 1'b1, 1);
        end

        // 5a: reset after five beats of a vector.
        rand_vec(C);
        send_beats(5, 1'b0, 0);
        pulse_reset("t5a_rst");
        rand_vec(C);
        pe_lat = 3;
        send_beats(C, 1'b0, 0);
        check_wait("t5a");
        take_result("t5a", ref_dot(), 1'b0, 0);

        // 5b: reset while waiting on the PE.
        pe_on = 1'b0;
        rand_vec(C);
        send_beats(C, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("t5b_in_wait", 64'(mul_enable), 64'd1);
        pulse_reset("t5b_rst");
        pe_on = 1'b1;
        rand_vec(C);
        pe_lat = 5;
        send_beats(C, 1'b0, 0);
        check_wait("t5b");
        take_result("t5b", ref_dot(), 1'b0, 0);

        // 6: random vectors with random lengths, gaps, PE latency and consumer stalls.
        for (int v = 0; v < 25; v++) begin
            n = $urandom_range(1, C);
            rand_vec(n);
            pe_lat = $urandom_range(1, 8);
            send_beats(n, (n < C) ? 1'b1 : 1'($urandom_range(0, 1)), 3);
            check_wait("t6");
            take_result("t6", ref_dot(), 1'b0, $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
